// File: rtl/uart_byte_assembler.sv
// Assembles 8N1 UART frames from sampler ticks into a one-deep holding register with valid/ready handoff.
// Commit appears 1 clock after the stop-bit tick; a full, unaccepted holding register drops the new byte and pulses overrun.
module uart_byte_assembler #(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk_25mhz,
  input  logic                 reset,
  input  logic                 sample_tick,
  input  logic                 sample_bit,
  output logic [DATA_BITS-1:0] rx_byte,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_error,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DATA      = 2'd1,
    STOP      = 2'd2,
    WAIT_HIGH = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_byte_q, rx_byte_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_error_q, frame_error_d;
  logic                 overrun_q, overrun_d;
  logic                 busy_q, busy_d;
  logic                 commit;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    shift_d       = shift_q;
    rx_byte_d     = rx_byte_q;
    rx_valid_d    = rx_valid_q;
    frame_error_d = 1'b0;
    overrun_d     = 1'b0;
    commit        = 1'b0;

    if (sample_tick) begin
      case (state_q)
        IDLE: begin
          if (!sample_bit) begin
            state_d = DATA;
            cnt_d   = '0;
          end
        end
        DATA: begin
          // LSB arrives first, so after DATA_BITS shifts it has walked down to bit 0
          shift_d              = shift_q >> 1;
          shift_d[DATA_BITS-1] = sample_bit;
          cnt_d                = cnt_q + CW'(1);
          if (cnt_q == LAST_BIT) begin
            state_d = STOP;
          end
        end
        STOP: begin
          if (sample_bit) begin
            commit  = 1'b1;
            state_d = IDLE;
          end else begin
            frame_error_d = 1'b1;
            state_d       = WAIT_HIGH;
          end
        end
        WAIT_HIGH: begin
          if (sample_bit) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // A same-cycle accept frees the slot, so the new byte may replace the old one
    if (commit) begin
      if (!rx_valid_q || rx_ready) begin
        rx_byte_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_25mhz or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      shift_q       <= '0;
      rx_byte_q     <= '0;
      rx_valid_q    <= 1'b0;
      frame_error_q <= 1'b0;
      overrun_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      shift_q       <= shift_d;
      rx_byte_q     <= rx_byte_d;
      rx_valid_q    <= rx_valid_d;
      frame_error_q <= frame_error_d;
      overrun_q     <= overrun_d;
      busy_q        <= busy_d;
    end
  end

  assign rx_byte     = rx_byte_q;
  assign rx_valid    = rx_valid_q;
  assign frame_error = frame_error_q;
  assign overrun     = overrun_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_uart_byte_assembler.sv
// Directed bench for uart_byte_assembler: drives sampler ticks frame by frame and
// scoreboards every byte handed over on a valid/ready handshake.
module tb_uart_byte_assembler;

  logic       clk_25mhz = 1'b0;
  logic       reset = 1'b1;
  logic       sample_tick = 1'b0;
  logic       sample_bit = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       frame_error;
  logic       overrun;
  logic       busy;

  int passed = 0;
  int total = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  logic [7:0] exp_q[$];

  uart_byte_assembler #(.DATA_BITS(8)) dut (
    .clk_25mhz  (clk_25mhz),
    .reset      (reset),
    .sample_tick(sample_tick),
    .sample_bit (sample_bit),
    .rx_byte    (rx_byte),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_error(frame_error),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #20 clk_25mhz = ~clk_25mhz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Inputs only move 1 ns after a rising edge, so the falling edge sees what the next edge will use
  always @(negedge clk_25mhz) begin
    if (!reset) begin
      if (frame_error) fe_cnt++;
      if (overrun) ov_cnt++;
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) chk("sb_extra_byte", 32'(exp_q.size()), 32'd1);
        else chk("sb_byte", {24'd0, rx_byte}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_25mhz);
      #1;
    end
  endtask

  task automatic tick(input logic b);
    sample_tick = 1'b1;
    sample_bit  = b;
    @(posedge clk_25mhz);
    #1;
    sample_tick = 1'b0;
    sample_bit  = 1'($urandom);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b,
                            input bit expect_commit, input bit rdy_at_stop);
    if (expect_commit) exp_q.push_back(d);
    tick(1'b0);
    idle(2);
    for (int i = 0; i < 8; i++) begin
      tick(d[i]);
      idle(2);
    end
    if (rdy_at_stop) rx_ready = 1'b1;
    tick(stop_b);
    if (rdy_at_stop) rx_ready = 1'b0;
  endtask

  initial begin
    logic stable;
    int   fe0;
    int   ov0;

    #5;
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_rx_byte", {24'd0, rx_byte}, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_error", 32'(frame_error), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    idle(3);
    reset = 1'b0;
    idle(2);

    // Idle line, then 0x55 with consumer ready
    for (int i = 0; i < 3; i++) begin
      tick(1'b1);
      idle(2);
    end
    chk("idle_busy", 32'(busy), 32'd0);
    rx_ready = 1'b1;
    send_frame(8'h55, 1'b1, 1'b1, 1'b0);
    chk("f55_valid", 32'(rx_valid), 32'd1);
    chk("f55_byte", {24'd0, rx_byte}, 32'h55);
    chk("f55_busy", 32'(busy), 32'd0);
    idle(1);
    chk("f55_valid_one_cycle", 32'(rx_valid), 32'd0);

    // 0xA3 held for 20 clocks while consumer stalls
    rx_ready = 1'b0;
    send_frame(8'hA3, 1'b1, 1'b1, 1'b0);
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      idle(1);
      if (!(rx_valid === 1'b1 && rx_byte === 8'hA3)) stable = 1'b0;
    end
    chk("fa3_held_stable", 32'(stable), 32'd1);
    rx_ready = 1'b1;
    idle(1);
    chk("fa3_cleared", 32'(rx_valid), 32'd0);
    rx_ready = 1'b0;

    // Back-to-back 0x12, 0x34 with no consumer: second is dropped
    ov0 = ov_cnt;
    send_frame(8'h12, 1'b1, 1'b1, 1'b0);
    send_frame(8'h34, 1'b1, 1'b0, 1'b0);
    chk("ovr_pulse", 32'(overrun), 32'd1);
    chk("ovr_byte_kept", {24'd0, rx_byte}, 32'h12);
    idle(1);
    chk("ovr_pulse_end", 32'(overrun), 32'd0);
    chk("ovr_count", 32'(ov_cnt - ov0), 32'd1);
    rx_ready = 1'b1;
    idle(1);
    rx_ready = 1'b0;
    chk("ovr_drained", 32'(rx_valid), 32'd0);

    // Bad stop bit on 0xFF, line break, then 0x0F
    rx_ready = 1'b1;
    fe0 = fe_cnt;
    send_frame(8'hFF, 1'b0, 1'b0, 1'b0);
    chk("fe_pulse", 32'(frame_error), 32'd1);
    chk("fe_no_commit", 32'(rx_valid), 32'd0);
    chk("fe_busy_wait", 32'(busy), 32'd1);
    idle(1);
    chk("fe_pulse_end", 32'(frame_error), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0);
      idle(2);
    end
    chk("fe_break_busy", 32'(busy), 32'd1);
    tick(1'b1);
    idle(2);
    chk("fe_rearm_idle", 32'(busy), 32'd0);
    send_frame(8'h0F, 1'b1, 1'b1, 1'b0);
    chk("f0f_valid", 32'(rx_valid), 32'd1);
    chk("f0f_byte", {24'd0, rx_byte}, 32'h0F);
    idle(1);
    chk("fe_count", 32'(fe_cnt - fe0), 32'd1);

    // Reset mid-frame with a byte still pending
    rx_ready = 1'b0;
    send_frame(8'h77, 1'b1, 1'b0, 1'b0);
    chk("pre_rst_valid", 32'(rx_valid), 32'd1);
    tick(1'b0);
    idle(2);
    for (int i = 0; i < 4; i++) begin
      tick(1'(8'hC6 >> i));
      idle(2);
    end
    chk("mid_frame_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #2;
    chk("arst_valid", 32'(rx_valid), 32'd0);
    chk("arst_byte", {24'd0, rx_byte}, 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_fe", 32'(frame_error), 32'd0);
    chk("arst_ovr", 32'(overrun), 32'd0);
    idle(2);
    reset = 1'b0;
    idle(2);
    rx_ready = 1'b1;
    send_frame(8'hC6, 1'b1, 1'b1, 1'b0);
    chk("fc6_byte", {24'd0, rx_byte}, 32'hC6);
    idle(1);
    rx_ready = 1'b0;

    // Consumer accepts 0x21 in the very cycle 0x9B commits
    send_frame(8'h21, 1'b1, 1'b1, 1'b0);
    idle(3);
    ov0 = ov_cnt;
    send_frame(8'h9B, 1'b1, 1'b1, 1'b1);
    chk("f9b_valid", 32'(rx_valid), 32'd1);
    chk("f9b_byte", {24'd0, rx_byte}, 32'h9B);
    chk("f9b_no_ovr", 32'(overrun), 32'd0);
    rx_ready = 1'b1;
    idle(1);
    rx_ready = 1'b0;
    chk("f9b_drained", 32'(rx_valid), 32'd0);
    chk("f9b_ovr_count", 32'(ov_cnt - ov0), 32'd0);

    idle(2);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uart_byte_assembler.md
UART_BYTE_ASSEMBLER -- requirements
Module: uart_byte_assembler

Interface
REQ-001 Parameter: DATA_BITS, default 8, number of data bits per frame (8N1 framing, LSB first).
REQ-002 Port: clk_25mhz  input  1  system clock, 25 MHz, all logic on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: sample_tick  input  1  one-cycle pulse from uart_sampler marking a new bit sample.
REQ-005 Port: sample_bit  input  1  newest sampled line bit (uart_sampler last_4_bits[0]); valid only in a sample_tick cycle.
REQ-006 Port: rx_byte  output  DATA_BITS  assembled data byte; stable while rx_valid=1.
REQ-007 Port: rx_valid  output  1  byte available in the holding register.
REQ-008 Port: rx_ready  input  1  consumer accepts rx_byte when rx_valid&&rx_ready at a rising edge.
REQ-009 Port: frame_error  output  1  one-cycle pulse, stop bit sampled as 0.
REQ-010 Port: overrun  output  1  one-cycle pulse, completed byte dropped because the holding register was full.
REQ-011 Port: busy  output  1  high in any state other than IDLE.

Function
REQ-012 The FSM SHALL have states IDLE, DATA, STOP and WAIT_HIGH; all transitions occur only in cycles with sample_tick=1.
REQ-013 IDLE: sample_bit=0 -> DATA, bit counter cleared to 0; sample_bit=1 -> stay IDLE.
REQ-014 DATA: each tick shifts sample_bit into the MSB of the shift register (LSB-first assembly) and increments the counter; the tick capturing bit DATA_BITS-1 -> STOP.
REQ-015 STOP: sample_bit=1 -> commit shift register, go IDLE; sample_bit=0 -> frame_error pulse, discard byte, go WAIT_HIGH.
REQ-016 WAIT_HIGH: sample_bit=1 -> IDLE; sample_bit=0 -> stay (line break); no start bit is recognised in this state.
REQ-017 A commit SHALL load rx_byte and set rx_valid on the rising edge ending the stop-bit tick cycle (latency 1 clock after the stop tick).
REQ-018 rx_valid SHALL clear on the edge where rx_valid&&rx_ready, unless a commit occurs in that same cycle.
REQ-019 Commit with rx_valid=1 and rx_ready=1 in the same cycle: new byte loaded, rx_valid stays 1, no overrun.
REQ-020 Commit with rx_valid=1 and rx_ready=0: old rx_byte retained, new byte dropped, overrun pulses one cycle.
REQ-021 Cycles without sample_tick SHALL not change the FSM, counter or shift register.
REQ-022 frame_error and overrun SHALL never be high two consecutive cycles for a single event.

Reset
REQ-023 On reset assertion, asynchronously: state IDLE, counter 0, shift register 0, rx_byte 0, rx_valid 0, frame_error 0, overrun 0, busy 0.
REQ-024 Reset asserted mid-frame SHALL abort the frame with no commit and no error pulse; reception re-arms on the first 0 sample after release.

Verification
REQ-025 Idle ticks with bit 1, then frame 0,1,0,1,0,1,0,1,0,1 (start, 0x55 LSB first, stop), rx_ready=1 -> rx_valid 1 for one cycle, rx_byte=0x55, busy low after stop.
REQ-026 Frame 0xA3 with rx_ready=0 for 20 clocks after commit -> rx_valid and rx_byte=0xA3 held stable until rx_ready=1, cleared on the following edge.
REQ-027 Two back-to-back frames 0x12 then 0x34 with rx_ready=0 throughout -> rx_byte stays 0x12, overrun pulses once at second stop tick.
REQ-028 Frame 0xFF with stop sample 0, then three 0 ticks, then 1, then frame 0x0F -> frame_error one pulse, no commit for 0xFF, no false start during the 0 run, rx_byte=0x0F.
REQ-029 Reset pulsed after 4 data bits of a frame -> all outputs 0 immediately; subsequent frame 0xC6 received correctly.
REQ-030 rx_ready=1 asserted in the exact commit cycle of 0x9B while 0x21 is pending -> 0x21 consumed, rx_byte=0x9B, rx_valid stays 1, no overrun.
